// File: rtl/nios2_debug_ocimem_pkg.sv
// nios2_debug_ocimem_pkg: shared FSM states and jdo field positions for the debug OCI memory
package nios2_debug_ocimem_pkg;
   typedef enum logic [2:0] {IDLE, J_RD, J_CAP, J_WR, C_ACC, C_DONE} state_t;
   localparam int JDO_ADDR_LSB  = 17;
   localparam int JDO_RD        = 34;
   localparam int JDO_CLR       = 35;
   localparam int JDO_WDATA_MSB = 34;
   localparam int JDO_WDATA_LSB = 3;
   localparam int REG_MON       = 0;
endpackage

// File: rtl/nios2_debug_ocimem_ram.sv
// nios2_debug_ocimem_ram: single-port 32-bit byte-enabled RAM with registered read
module nios2_debug_ocimem_ram #(
  parameter int    ADDR_W    = 8,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       q
);
  logic [31:0] mem [2**ADDR_W];
  initial for (int i = 0; i < 2**ADDR_W; i++) mem[i] = '0;
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (we && be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
    q <= mem[addr];
  end
endmodule

// File: rtl/nios2_debug_ocimem.sv
// nios2_debug_ocimem: debug RAM shared between JTAG commands and the CPU debug slave, plus monitor flags
module nios2_debug_ocimem
   import nios2_debug_ocimem_pkg::*;
#(
   parameter int    ADDR_W        = 8,
   parameter string RAM_INIT_FILE = ""
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [37:0]     jdo,
   input  logic            take_action_ocimem_a,
   input  logic            take_action_ocimem_b,
   input  logic            take_no_action_ocimem_a,
   input  logic [ADDR_W:0] avs_address,
   input  logic            avs_read,
   input  logic            avs_write,
   input  logic [31:0]     avs_writedata,
   input  logic [3:0]      avs_byteenable,
   output logic [31:0]     avs_readdata,
   output logic            avs_waitrequest,
   output logic [31:0]     MonDReg,
   output logic            monitor_ready,
   output logic            monitor_error
);
   state_t            state, nxt;
   logic [ADDR_W-1:0] jaddr, ram_addr;
   logic              jrd_pend, jwr_pend, ram_we, reg_set, flag_clr, unused;
   logic [31:0]       jwdata, rdata_q, ram_q, ram_wdata;
   logic [3:0]        ram_be;
   wire cpu_req  = avs_read | avs_write;
   wire csel     = avs_address[ADDR_W];
   wire reg0     = avs_address[ADDR_W-1:0] == ADDR_W'(REG_MON);
   wire take_any = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
   wire jacc     = state == J_RD || state == J_WR;
   assign unused = ^{jdo[37:36], jdo[2:0]};
   assign ram_addr  = jacc ? jaddr : avs_address[ADDR_W-1:0];
   assign ram_we    = state == J_WR || (state == C_ACC && avs_write && !csel);
   assign ram_be    = state == J_WR ? 4'hF : avs_byteenable;
   assign ram_wdata = state == J_WR ? jwdata : avs_writedata;
   assign reg_set   = state == C_ACC && avs_write && csel && reg0;
   assign flag_clr  = take_action_ocimem_a && jdo[JDO_CLR];
   assign avs_waitrequest = cpu_req && state != C_DONE;
   assign avs_readdata = (state == C_DONE && !csel) ? ram_q : rdata_q;

   nios2_debug_ocimem_ram #(.ADDR_W(ADDR_W), .INIT_FILE(RAM_INIT_FILE)) u_ram (
      .clk(clk), .addr(ram_addr), .we(ram_we), .be(ram_be), .wdata(ram_wdata), .q(ram_q)
   );

   // state register
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= nxt;

   // arbitration: pending JTAG first; a strobe arriving this cycle also holds off a new CPU access
   always_comb begin
      nxt = IDLE;
      unique case (state)
         IDLE:    nxt = jrd_pend ? J_RD : jwr_pend ? J_WR : (!take_any && cpu_req) ? C_ACC : IDLE;
         J_RD:    nxt = J_CAP;
         C_ACC:   nxt = C_DONE;
         default: nxt = IDLE;
      endcase
   end

   // JTAG command capture; a fresh strobe overrides completion bookkeeping in the same cycle
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         jaddr    <= '0;
         jrd_pend <= 1'b0;
         jwr_pend <= 1'b0;
         jwdata   <= '0;
      end else begin
         if (state == J_CAP || state == J_WR) begin
            jaddr    <= jaddr + 1'b1;
            jrd_pend <= 1'b0;
            jwr_pend <= 1'b0;
         end
         if (take_action_ocimem_a) jaddr <= jdo[JDO_ADDR_LSB +: ADDR_W];
         if ((take_action_ocimem_a && jdo[JDO_RD]) || take_no_action_ocimem_a) begin
            jrd_pend <= 1'b1;
            jwr_pend <= 1'b0;
         end
         if (take_action_ocimem_b) begin
            jwr_pend <= 1'b1;
            jrd_pend <= 1'b0;
            jwdata   <= jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
         end
      end

   // MonDReg, monitor flags (CPU set beats JTAG clear) and held CPU read data
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         MonDReg       <= '0;
         monitor_ready <= 1'b0;
         monitor_error <= 1'b0;
         rdata_q       <= '0;
      end else begin
         if (state == J_CAP) MonDReg <= ram_q;
         monitor_ready <= (reg_set && avs_writedata[0]) ? 1'b1 : flag_clr ? 1'b0 : monitor_ready;
         monitor_error <= (reg_set && avs_writedata[1]) ? 1'b1 : flag_clr ? 1'b0 : monitor_error;
         if (state == C_ACC && !avs_write && csel)
            rdata_q <= reg0 ? {30'b0, monitor_error, monitor_ready} : 32'b0;
         if (state == C_DONE && !avs_write && !csel) rdata_q <= ram_q;
      end
endmodule

// File: tb/tb_nios2_debug_ocimem.sv
// tb_nios2_debug_ocimem: directed bench with a word-level memory/flag model checked every cycle
module tb_nios2_debug_ocimem;
   localparam int AW = 8;
   logic          clk = 1'b0, reset = 1'b1;
   logic [37:0]   jdo = '0;
   logic          ta = 1'b0, tb = 1'b0, tn = 1'b0;
   logic [AW:0]   avs_address = '0;
   logic          avs_read = 1'b0, avs_write = 1'b0;
   logic [31:0]   avs_writedata = '0;
   logic [3:0]    avs_byteenable = '0;
   logic [31:0]   avs_readdata, MonDReg;
   logic          avs_waitrequest, monitor_ready, monitor_error;
   int            n_chk = 0, n_pass = 0;
   logic [31:0]   mem_m [256];
   logic [7:0]    jaddr_m = '0;
   logic [31:0]   mon_m = '0, r;
   logic          rdy_m = 1'b0, err_m = 1'b0, run = 1'b0;

   nios2_debug_ocimem #(.ADDR_W(AW), .RAM_INIT_FILE("")) dut (
      .clk(clk), .reset(reset), .jdo(jdo),
      .take_action_ocimem_a(ta), .take_action_ocimem_b(tb), .take_no_action_ocimem_a(tn),
      .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
      .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
      .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest),
      .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // continuous comparison of the JTAG-visible outputs against the model
   always @(negedge clk)
      if (run) begin
         check("MonDReg", MonDReg, mon_m);
         check("monitor_ready", 32'(monitor_ready), 32'(rdy_m));
         check("monitor_error", 32'(monitor_error), 32'(err_m));
         if (!(avs_read || avs_write)) check("waitrequest_idle", 32'(avs_waitrequest), 32'd0);
      end

   task automatic jtag_read_tail();
      repeat (2) @(posedge clk);
      @(posedge clk);
      #1 mon_m = mem_m[jaddr_m];
      jaddr_m++;
      @(posedge clk);
   endtask

   task automatic jtag_a(input logic [7:0] a, input logic rd, input logic clr);
      @(posedge clk);
      #1 jdo = '0; jdo[24:17] = a; jdo[34] = rd; jdo[35] = clr; ta = 1'b1;
      @(posedge clk);
      #1 ta = 1'b0; jaddr_m = a;
      if (clr) begin rdy_m = 1'b0; err_m = 1'b0; end
      if (rd) jtag_read_tail();
      else repeat (3) @(posedge clk);
   endtask

   task automatic jtag_n();
      @(posedge clk);
      #1 tn = 1'b1;
      @(posedge clk);
      #1 tn = 1'b0;
      jtag_read_tail();
   endtask

   task automatic jtag_b(input logic [31:0] d);
      @(posedge clk);
      #1 jdo = '0; jdo[34:3] = d; tb = 1'b1;
      @(posedge clk);
      #1 tb = 1'b0;
      repeat (2) @(posedge clk);
      #1 mem_m[jaddr_m] = d; jaddr_m++;
      @(posedge clk);
   endtask

   task automatic cpu(input logic wr, input logic [AW:0] a, input logic [31:0] d,
                      input logic [3:0] be, output logic [31:0] rd);
      int k;
      logic [31:0] exp;
      @(posedge clk);
      #1 avs_address = a; avs_write = wr; avs_read = !wr; avs_writedata = d; avs_byteenable = be;
      k = 0;
      do begin @(posedge clk); #1 k++; end while (avs_waitrequest && k < 20);
      check("cpu_complete", 32'(avs_waitrequest), 32'd0);
      check("cpu_min_wait", 32'(k >= 2), 32'd1);
      rd = avs_readdata;
      exp = a[AW] ? (a[AW-1:0] == 0 ? {30'b0, err_m, rdy_m} : 32'b0) : mem_m[a[AW-1:0]];
      if (!wr) check("cpu_read_model", rd, exp);
      if (wr && a[AW] && a[AW-1:0] == 0) begin
         if (d[0]) rdy_m = 1'b1;
         if (d[1]) err_m = 1'b1;
      end
      if (wr && !a[AW])
         for (int i = 0; i < 4; i++) if (be[i]) mem_m[a[AW-1:0]][i*8 +: 8] = d[i*8 +: 8];
      @(posedge clk);
      #1 avs_read = 1'b0; avs_write = 1'b0;
   endtask

   task automatic cpu_wr(input logic [AW:0] a, input logic [31:0] d, input logic [3:0] be);
      logic [31:0] dummy;
      cpu(1'b1, a, d, be, dummy);
   endtask

   task automatic cpu_rd(input string name, input logic [AW:0] a, input logic [31:0] exp);
      logic [31:0] got;
      cpu(1'b0, a, 32'b0, 4'h0, got);
      check(name, got, exp);
   endtask

   initial begin
      int k;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      run = 1'b1;
      check("rst_MonDReg", MonDReg, 32'h0);
      check("rst_ready", 32'(monitor_ready), 32'd0);
      check("rst_waitrequest", 32'(avs_waitrequest), 32'd0);
      check("rst_readdata", avs_readdata, 32'h0);
      // JTAG writes, CPU reads back
      jtag_a(8'h10, 1'b0, 1'b0);
      jtag_b(32'hDEADBEEF);
      jtag_b(32'h12345678);
      cpu_rd("cpu_rd_10", 9'h010, 32'hDEADBEEF);
      cpu_rd("cpu_rd_11", 9'h011, 32'h12345678);
      // byte enables
      cpu_wr(9'h010, 32'hFFFFFFFF, 4'h0);
      cpu_rd("be_zero", 9'h010, 32'hDEADBEEF);
      cpu_wr(9'h011, 32'h0000AB00, 4'b0010);
      cpu_rd("be_lane1", 9'h011, 32'h1234AB78);
      // JTAG read and read-next
      cpu_wr(9'h020, 32'hA5A50001, 4'hF);
      cpu_wr(9'h021, 32'h0BADF00D, 4'hF);
      jtag_a(8'h20, 1'b1, 1'b0);
      check("jrd_20", MonDReg, 32'hA5A50001);
      jtag_n();
      check("jrd_next_21", MonDReg, 32'h0BADF00D);
      // address wrap
      cpu_wr(9'h0FF, 32'h11110000, 4'hF);
      cpu_wr(9'h000, 32'h22220000, 4'hF);
      jtag_a(8'hFF, 1'b1, 1'b0);
      check("jrd_ff", MonDReg, 32'h11110000);
      jtag_n();
      check("jrd_wrap_00", MonDReg, 32'h22220000);
      // same-clock JTAG read and CPU read: JTAG first
      cpu_wr(9'h030, 32'hCAFE0030, 4'hF);
      cpu_wr(9'h031, 32'hFACE0031, 4'hF);
      @(posedge clk);
      #1 jdo = '0; jdo[24:17] = 8'h30; jdo[34] = 1'b1; ta = 1'b1;
      avs_address = 9'h031; avs_read = 1'b1;
      @(posedge clk);
      #1 ta = 1'b0; jaddr_m = 8'h30;
      repeat (2) @(posedge clk);
      @(posedge clk);
      #1 mon_m = mem_m[jaddr_m]; jaddr_m++;
      check("arb_jtag_first", MonDReg, 32'hCAFE0030);
      check("arb_cpu_waiting", 32'(avs_waitrequest), 32'd1);
      k = 0;
      do begin @(posedge clk); #1 k++; end while (avs_waitrequest && k < 20);
      check("arb_cpu_done", 32'(avs_waitrequest), 32'd0);
      check("arb_cpu_data", avs_readdata, 32'hFACE0031);
      @(posedge clk);
      #1 avs_read = 1'b0;
      // monitor flags
      cpu_wr(9'h100, 32'h3, 4'hF);
      check("flags_set", {30'b0, monitor_error, monitor_ready}, 32'h3);
      cpu_rd("reg0_rd", 9'h100, 32'h3);
      cpu_rd("reg1_rd", 9'h101, 32'h0);
      cpu_wr(9'h101, 32'h0, 4'hF);
      cpu_rd("reg0_after_reg1_wr", 9'h100, 32'h3);
      jtag_a(8'h00, 1'b0, 1'b1);
      check("flags_clr", {30'b0, monitor_error, monitor_ready}, 32'h0);
      // set and clear in the same clock: set wins
      @(posedge clk);
      #1 avs_address = 9'h100; avs_write = 1'b1; avs_writedata = 32'h3; avs_byteenable = 4'hF;
      @(posedge clk);
      #1 jdo = '0; jdo[35] = 1'b1; ta = 1'b1;
      @(posedge clk);
      #1 ta = 1'b0; jaddr_m = 8'h00; rdy_m = 1'b1; err_m = 1'b1;
      check("setclr_done", 32'(avs_waitrequest), 32'd0);
      @(posedge clk);
      #1 avs_write = 1'b0;
      check("setclr_flags", {30'b0, monitor_error, monitor_ready}, 32'h3);
      repeat (3) @(posedge clk);
      // reset during J_RD
      @(posedge clk);
      #1 jdo = '0; jdo[24:17] = 8'h20; jdo[34] = 1'b1; ta = 1'b1;
      @(posedge clk);
      #1 ta = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1; mon_m = '0; rdy_m = 1'b0; err_m = 1'b0; jaddr_m = '0;
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (4) @(posedge clk);
      #1 check("rst_mid_jrd_MonDReg", MonDReg, 32'h0);
      jtag_n();
      check("post_rst_jaddr0", MonDReg, 32'h22220000);
      run = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
